// File: rtl/rpxx_seek_pkg.sv
// Shared encodings and default timing for the RPxx head-positioning sequencer.
// The package plays the role of the old rpsk.vh include.
package rpxx_seek_pkg;

  localparam int RPSK_MAXCYL    = 815;
  localparam int RPSK_STEPCYC   = 1000;
  localparam int RPSK_SETTLECYC = 5000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_STEP   = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } rpsk_state_e;

  typedef enum logic [1:0] {
    K_SEEK  = 2'd0,
    K_RECAL = 2'd1,
    K_XFER  = 2'd2
  } rpsk_kind_e;

  // Timer must hold max(STEPCYC,SETTLECYC)-1.
  function automatic int tmr_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rpxx_seek_tmr.sv
// Loadable down-counter shared by the step and settle phases.
// It holds at zero; zero_nxt_o tells the caller the counter will read zero next cycle.
module rpxx_seek_tmr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o,
  output logic         zero_nxt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o     = (cnt_q == '0);
  assign zero_nxt_o = (cnt_d == '0);

endmodule

// File: rtl/rpxx_seek.sv
// Head-positioning sequencer: owns the current cylinder address and models
// seek/recal motion one cylinder per step period, followed by head settle.
module rpxx_seek
  import rpxx_seek_pkg::*;
#(
  parameter int MAXCYL    = RPSK_MAXCYL,
  parameter int STEPCYC   = RPSK_STEPCYC,
  parameter int SETTLECYC = RPSK_SETTLECYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] rpDCA,
  input  logic       rpSEEK,
  input  logic       rpRECAL,
  input  logic       rpXFER,
  input  logic       rpINCCYL,
  output logic [9:0] rpCCA,
  output logic       rpDRY,
  output logic       rpPIP,
  output logic       rpSETATA,
  output logic       rpSETIAE,
  output logic       rpXFERGO
);

  localparam int TW = tmr_width(STEPCYC, SETTLECYC);
  localparam logic [9:0] MAXC = 10'(MAXCYL);

  rpsk_state_e state_q, state_d;
  rpsk_kind_e  kind_q, kind_d;
  logic [9:0]  tgt_q, tgt_d;
  logic [9:0]  cca_q, cca_d;
  logic        bad_q, bad_d;
  logic        dry_q, pip_q, ata_q, iae_q, xgo_q;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero, tmr_zero_nxt;

  rpxx_seek_tmr #(.W(TW)) u_tmr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .val_i      (tmr_val),
    .zero_o     (tmr_zero),
    .zero_nxt_o (tmr_zero_nxt)
  );

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    tgt_d    = tgt_q;
    bad_d    = bad_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      S_IDLE: begin
        if (rpRECAL) begin
          kind_d  = K_RECAL;
          tgt_d   = '0;
          bad_d   = 1'b0;
          state_d = S_CHECK;
        end else if (rpSEEK || rpXFER) begin
          kind_d  = rpSEEK ? K_SEEK : K_XFER;
          tgt_d   = rpDCA;
          bad_d   = (rpDCA > MAXC);
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bad_q || tgt_q == cca_q) begin
          state_d = S_DONE;
        end else begin
          state_d  = S_STEP;
          tmr_load = 1'b1;
          tmr_val  = TW'(STEPCYC - 1);
        end
      end
      S_STEP: begin
        // cca_q already shows the step taken in this cycle.
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (cca_q == tgt_q) begin
            state_d = S_SETTLE;
            tmr_val = TW'(SETTLECYC - 1);
          end else begin
            tmr_val = TW'(STEPCYC - 1);
          end
        end
      end
      S_SETTLE: begin
        if (tmr_zero) state_d = S_DONE;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // CCA moves on the edge entering the last cycle of each step period,
  // so the new address is visible during that cycle.
  always_comb begin
    cca_d = cca_q;
    if (state_q == S_IDLE) begin
      if (rpINCCYL && cca_q < MAXC) cca_d = cca_q + 10'd1;
    end else if (state_d == S_STEP && tmr_zero_nxt) begin
      cca_d = (tgt_q > cca_q) ? cca_q + 10'd1 : cca_q - 10'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      kind_q  <= K_SEEK;
      tgt_q   <= '0;
      cca_q   <= '0;
      bad_q   <= 1'b0;
      dry_q   <= 1'b1;
      pip_q   <= 1'b0;
      ata_q   <= 1'b0;
      iae_q   <= 1'b0;
      xgo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      tgt_q   <= tgt_d;
      cca_q   <= cca_d;
      bad_q   <= bad_d;
      dry_q   <= (state_d == S_IDLE);
      pip_q   <= (state_d != S_IDLE) && (kind_d != K_XFER);
      ata_q   <= (state_d == S_DONE) && (kind_d != K_XFER || bad_d);
      iae_q   <= (state_q == S_IDLE) && (state_d == S_CHECK) && bad_d;
      xgo_q   <= (state_d == S_DONE) && (kind_d == K_XFER) && !bad_d;
    end
  end

  assign rpCCA    = cca_q;
  assign rpDRY    = dry_q;
  assign rpPIP    = pip_q;
  assign rpSETATA = ata_q;
  assign rpSETIAE = iae_q;
  assign rpXFERGO = xgo_q;

endmodule

// File: tb/tb_rpxx_seek.sv
// Directed bench for rpxx_seek with short step/settle times (STEPCYC=4, SETTLECYC=8).
// Cycle n means the clock period following command-sampling edge n-1.
module tb_rpxx_seek;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] rpDCA = '0;
  logic       rpSEEK = 1'b0, rpRECAL = 1'b0, rpXFER = 1'b0, rpINCCYL = 1'b0;
  logic [9:0] rpCCA;
  logic       rpDRY, rpPIP, rpSETATA, rpSETIAE, rpXFERGO;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ata_cnt = 0, iae_cnt = 0, xgo_cnt = 0;
  int base;

  rpxx_seek #(.MAXCYL(815), .STEPCYC(4), .SETTLECYC(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .rpDCA    (rpDCA),
    .rpSEEK   (rpSEEK),
    .rpRECAL  (rpRECAL),
    .rpXFER   (rpXFER),
    .rpINCCYL (rpINCCYL),
    .rpCCA    (rpCCA),
    .rpDRY    (rpDRY),
    .rpPIP    (rpPIP),
    .rpSETATA (rpSETATA),
    .rpSETIAE (rpSETIAE),
    .rpXFERGO (rpXFERGO)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (rpSETATA) ata_cnt++;
      if (rpSETIAE) iae_cnt++;
      if (rpXFERGO) xgo_cnt++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) adv();
  endtask

  // kind: 0 seek, 1 recal, 2 xfer; sampled at edge 0, returns in cycle 1.
  task automatic issue(input int kind, input logic [9:0] dca);
    rpDCA   = dca;
    rpSEEK  = (kind == 0);
    rpRECAL = (kind == 1);
    rpXFER  = (kind == 2);
    @(posedge clk);
    #1;
    cyc = 1;
    rpSEEK = 1'b0; rpRECAL = 1'b0; rpXFER = 1'b0;
  endtask

  initial begin
    #23 rst = 1'b0;
    adv();
    chk("rst_cca", rpCCA, 0);
    chk("rst_dry", rpDRY, 1);
    chk("rst_pip", rpPIP, 0);
    chk("rst_pulses", {rpSETATA, rpSETIAE, rpXFERGO}, 0);

    // seek 0 -> 3
    base = ata_cnt;
    issue(0, 10'd3);
    chk("s3_dry_c1", rpDRY, 0);
    chk("s3_pip_c1", rpPIP, 1);
    go_to(4);  chk("s3_cca_c4", rpCCA, 0);
    go_to(5);  chk("s3_cca_c5", rpCCA, 1);
    go_to(8);  chk("s3_cca_c8", rpCCA, 1);
    go_to(9);  chk("s3_cca_c9", rpCCA, 2);
    go_to(13); chk("s3_cca_c13", rpCCA, 3);
    go_to(21); chk("s3_ata_c21", rpSETATA, 0);
    go_to(22); chk("s3_ata_c22", rpSETATA, 1);
    chk("s3_dry_c22", rpDRY, 0);
    chk("s3_pip_c22", rpPIP, 1);
    go_to(23); chk("s3_dry_c23", rpDRY, 1);
    chk("s3_pip_c23", rpPIP, 0);
    chk("s3_ata_once", ata_cnt - base, 1);

    // invalid address
    base = ata_cnt;
    issue(0, 10'd816);
    chk("iae_c1", rpSETIAE, 1);
    chk("iae_cca_c1", rpCCA, 3);
    go_to(2);  chk("iae_ata_c2", rpSETATA, 1);
    chk("iae_off_c2", rpSETIAE, 0);
    go_to(3);  chk("iae_dry_c3", rpDRY, 1);
    chk("iae_cca_c3", rpCCA, 3);
    chk("iae_count", iae_cnt, 1);

    // seek 3 -> 2, then recal
    issue(0, 10'd2);
    go_to(15); chk("s2_cca", rpCCA, 2);
    base = ata_cnt;
    issue(1, 10'd500);
    chk("rc_pip_c1", rpPIP, 1);
    go_to(5);  chk("rc_cca_c5", rpCCA, 1);
    go_to(9);  chk("rc_cca_c9", rpCCA, 0);
    go_to(17); chk("rc_ata_c17", rpSETATA, 0);
    go_to(18); chk("rc_ata_c18", rpSETATA, 1);
    go_to(19); chk("rc_dry_c19", rpDRY, 1);
    chk("rc_cca_end", rpCCA, 0);

    // seek 0 -> 5, then transfers
    issue(0, 10'd5);
    go_to(31); chk("s5_cca", rpCCA, 5);
    chk("s5_dry", rpDRY, 1);
    base = ata_cnt;
    issue(2, 10'd5);
    chk("x5_pip_c1", rpPIP, 0);
    chk("x5_dry_c1", rpDRY, 0);
    go_to(2);  chk("x5_xgo_c2", rpXFERGO, 1);
    go_to(3);  chk("x5_dry_c3", rpDRY, 1);
    chk("x5_no_ata", ata_cnt - base, 0);
    issue(2, 10'd6);
    go_to(5);  chk("x6_cca_c5", rpCCA, 6);
    go_to(6);  chk("x6_pip_c6", rpPIP, 0);
    go_to(13); chk("x6_xgo_c13", rpXFERGO, 0);
    go_to(14); chk("x6_xgo_c14", rpXFERGO, 1);
    go_to(15); chk("x6_dry_c15", rpDRY, 1);
    chk("x6_no_ata", ata_cnt - base, 0);
    chk("xgo_count", xgo_cnt, 2);

    // seek 6 -> 10 with a second seek and DCA change during motion
    base = ata_cnt;
    issue(0, 10'd10);
    go_to(3);
    rpSEEK = 1'b1; rpDCA = 10'd20;
    adv();
    rpSEEK = 1'b0;
    go_to(26); chk("s10_ata_c26", rpSETATA, 1);
    go_to(27); chk("s10_cca", rpCCA, 10);
    chk("s10_dry", rpDRY, 1);
    go_to(30); chk("s10_still_idle", rpDRY, 1);
    chk("s10_ata_once", ata_cnt - base, 1);

    // seek 10 -> 814, then spiral past the top cylinder
    issue(0, 10'd814);
    go_to(3227); chk("s814_cca", rpCCA, 814);
    chk("s814_dry", rpDRY, 1);
    rpINCCYL = 1'b1;
    adv();
    rpINCCYL = 1'b0;
    chk("inc_to_815", rpCCA, 815);
    rpINCCYL = 1'b1;
    adv();
    rpINCCYL = 1'b0;
    chk("inc_at_max", rpCCA, 815);

    // reset during a seek 815 -> 0
    issue(0, 10'd0);
    go_to(5);  chk("rs_cca_c5", rpCCA, 814);
    go_to(6);
    #2 rst = 1'b1;
    #1;
    chk("rs_cca", rpCCA, 0);
    chk("rs_dry", rpDRY, 1);
    chk("rs_pip", rpPIP, 0);
    #3 rst = 1'b0;
    adv();
    base = ata_cnt;
    issue(0, 10'd2);
    chk("rs2_dry_c1", rpDRY, 0);
    go_to(5);  chk("rs2_cca_c5", rpCCA, 1);
    go_to(9);  chk("rs2_cca_c9", rpCCA, 2);
    go_to(18); chk("rs2_ata_c18", rpSETATA, 1);
    go_to(19); chk("rs2_dry_c19", rpDRY, 1);
    chk("rs2_ata_once", ata_cnt - base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
